ysyx_23060025_wb_arb: RTL
=========================

// Module: ysyx_23060025_wb_arb
// PURPOSE
//  Two-source arbiter for the single writeback (GPR/CSR write) path of the core.
//  s0 = EXU/CSR result stream, s1 = LSU load-result stream; each source uses valid/ready.
//  Winner is captured in a one-entry output register feeding the WB stage via m_valid/m_allowin.
//  Round-robin between sources; in-order within a source; no ordering guarantee across sources.
// PARAMETERS
//  DATA_LEN   32  width of GPR/CSR write data and mcause
//  REG_AW     5   GPR index width
//  CSR_AW     12  CSR address width
// PORTS
//  clock        in   1         clock
//  reset        in   1         sync active-high reset
//  sN_valid     in   1         source N (N=0,1) has a writeback beat
//  sN_ready     out  1         source N beat accepted this cycle (when sN_valid)
//  sN_wd        in   1         GPR write enable
//  sN_wreg      in   REG_AW    GPR index
//  sN_wdata     in   DATA_LEN  GPR data
//  sN_csr_type  in   3         CSR op type (0 = none)
//  sN_csr_waddr in   CSR_AW    CSR address
//  sN_csr_wdata in   DATA_LEN  CSR data
//  m_valid      out  1         output register holds a beat
//  m_allowin    in   1         WB stage accepts beat this cycle
//  m_wd, m_wreg, m_wdata, m_csr_type, m_csr_waddr, m_csr_wdata  out  (as sN_*)  granted beat
// BEHAVIOUR
//  - Reset: m_valid=0, all m_* data =0, rr pointer ptr=0 (s0 favoured first), sN_ready=0.
//  - can_load = ~m_valid | m_allowin (combinational).
//  - sN_ready = can_load & (ptr==N | ~s(1-N)_valid); never depends on own sN_valid.
//  - Transfer on sN_valid & sN_ready; at most one source per cycle (guaranteed by ready rule).
//  - On transfer: output reg loads beat at next edge, m_valid<=1, ptr <= ~N.
//  - m_allowin & m_valid & no transfer: m_valid<=0, data held.
//  - m_allowin & new transfer same cycle: old beat retires, new beat loads (zero bubble).
//  - m_valid & ~m_allowin: sN_ready=0, all m_* stable until accepted.
//  - Latency: 1 cycle source->m_valid; sustained throughput 1 beat/cycle.
//  - ptr changes only on a transfer; single source valid never starves (gets ready when can_load).
//  - Both valid every cycle, m_allowin=1: grants alternate s0,s1,s0,...
//  - Qualification: m_wd = reg_wd & m_valid & (reg_wreg!=0); m_csr_type = reg_csr_type & {3{m_valid}}.
//  - Reset mid-operation: pending beat dropped, no write reaches WB, ptr returns to 0.
// CONFIGURATION
//  Macro WB_ARB_PERF_EN:
//   defined: extra outputs perf_conflict, perf_stall, perf_grant0, perf_grant1 (32b each,
//    saturating at all-ones, cleared on reset). conflict: cycles with s0_valid&s1_valid;
//    stall: cycles with m_valid&~m_allowin; grantN: transfers from source N.
//   undefined: counters and ports absent; arbitration behaviour identical.
// STRUCTURE
//  Shared define file: CSR op type codes, REG_AW/CSR_AW defaults, beat-field widths.
//  Sub-module ysyx_23060025_wb_arb_perf: saturating counter bank, instantiated only under macro.
//  Arbiter core (ptr, ready logic, output register) stays in this module.
// TESTING
//  1. s0 only: wd=1,wreg=5,wdata=0x1234 -> s0_ready=1; next cycle m_valid=1,m_wreg=5,m_wdata=0x1234,m_wd=1.
//  2. s0,s1 valid 4 cycles, m_allowin=1, after reset -> m beats from s0,s1,s0,s1; no bubbles.
//  3. m_valid=1, m_allowin=0 for 5 cycles -> s0_ready=s1_ready=0, m_* unchanged; raise m_allowin
//     -> queued beat loads same cycle, m_valid stays 1.
//  4. s1 wd=1,wreg=0,wdata=0xdead -> m_valid=1, m_wd=0; csr_type=3 when m_valid=0 -> m_csr_type=0.
//  5. reset asserted with m_valid=1 -> next cycle m_valid=0,m_wd=0; then s0,s1 both valid -> s0 first.
//  6. WB_ARB_PERF_EN: 3 conflict cycles, 2 stall cycles -> perf_conflict=3, perf_stall=2;
//     counter preloaded near max -> holds 0xffffffff. Macro off: build has no perf ports.

Source files
------------

// File: rtl/ysyx_23060025_wb_arb_pkg.sv
// Shared definitions for the writeback arbiter: CSR op type codes, default
// address/data widths and beat-field widths.
package ysyx_23060025_wb_arb_pkg;

    localparam int unsigned DATA_LEN_DEF = 32;
    localparam int unsigned REG_AW_DEF   = 5;
    localparam int unsigned CSR_AW_DEF   = 12;
    localparam int unsigned CSR_TYPE_W   = 3;
    localparam int unsigned PERF_CNT_W   = 32;

    typedef enum logic [CSR_TYPE_W-1:0] {
        CsrNone  = 3'd0,
        CsrRw    = 3'd1,
        CsrRs    = 3'd2,
        CsrRc    = 3'd3,
        CsrEcall = 3'd4,
        CsrMret  = 3'd5
    } csr_type_e;

    // Total payload bits carried by one writeback beat.
    function automatic int unsigned beat_width(input int unsigned data_len,
                                               input int unsigned reg_aw,
                                               input int unsigned csr_aw);
        return 1 + reg_aw + data_len + CSR_TYPE_W + csr_aw + data_len;
    endfunction

endpackage

// File: rtl/ysyx_23060025_wb_arb_if.sv
// One valid/ready writeback beat channel. The producer side uses the master
// modport, the consumer side the slave modport.
interface ysyx_23060025_wb_arb_if
    import ysyx_23060025_wb_arb_pkg::*;
#(
    parameter int unsigned DATA_LEN = DATA_LEN_DEF,
    parameter int unsigned REG_AW   = REG_AW_DEF,
    parameter int unsigned CSR_AW   = CSR_AW_DEF
) ();

    logic                  valid;
    logic                  ready;
    logic                  wd;
    logic [REG_AW-1:0]     wreg;
    logic [DATA_LEN-1:0]   wdata;
    logic [CSR_TYPE_W-1:0] csr_type;
    logic [CSR_AW-1:0]     csr_waddr;
    logic [DATA_LEN-1:0]   csr_wdata;

    modport master (
        output valid, wd, wreg, wdata, csr_type, csr_waddr, csr_wdata,
        input  ready
    );

    modport slave (
        input  valid, wd, wreg, wdata, csr_type, csr_waddr, csr_wdata,
        output ready
    );

endinterface

// File: rtl/ysyx_23060025_wb_arb_perf.sv
// Saturating performance counter bank for the writeback arbiter.
// Only present when WB_ARB_PERF_EN is defined.
`ifdef WB_ARB_PERF_EN
module ysyx_23060025_wb_arb_perf
    import ysyx_23060025_wb_arb_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  s0_valid,
    input  logic                  s1_valid,
    input  logic                  m_valid,
    input  logic                  m_allowin,
    input  logic                  grant0,
    input  logic                  grant1,
    output logic [PERF_CNT_W-1:0] perf_conflict,
    output logic [PERF_CNT_W-1:0] perf_stall,
    output logic [PERF_CNT_W-1:0] perf_grant0,
    output logic [PERF_CNT_W-1:0] perf_grant1
);

    logic [PERF_CNT_W-1:0] conflict_q, stall_q, grant0_q, grant1_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            conflict_q <= '0;
            stall_q    <= '0;
            grant0_q   <= '0;
            grant1_q   <= '0;
        end else begin
            // Each counter sticks at all-ones instead of wrapping.
            if (s0_valid && s1_valid && conflict_q != '1) conflict_q <= conflict_q + 1'b1;
            if (m_valid && !m_allowin && stall_q != '1)    stall_q    <= stall_q + 1'b1;
            if (grant0 && grant0_q != '1)                  grant0_q   <= grant0_q + 1'b1;
            if (grant1 && grant1_q != '1)                  grant1_q   <= grant1_q + 1'b1;
        end
    end

    assign perf_conflict = conflict_q;
    assign perf_stall    = stall_q;
    assign perf_grant0   = grant0_q;
    assign perf_grant1   = grant1_q;

endmodule
`endif

// File: rtl/ysyx_23060025_wb_arb.sv
// Round-robin two-source arbiter for the single GPR/CSR writeback path.
// Optional counter bank enabled by WB_ARB_PERF_EN.
module ysyx_23060025_wb_arb
    import ysyx_23060025_wb_arb_pkg::*;
#(
    parameter int unsigned DATA_LEN = DATA_LEN_DEF,
    parameter int unsigned REG_AW   = REG_AW_DEF,
    parameter int unsigned CSR_AW   = CSR_AW_DEF
) (
    input logic                    clock,
    input logic                    reset,
    ysyx_23060025_wb_arb_if.slave  s0,
    ysyx_23060025_wb_arb_if.slave  s1,
    ysyx_23060025_wb_arb_if.master m
`ifdef WB_ARB_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0]  perf_conflict,
    output logic [PERF_CNT_W-1:0]  perf_stall,
    output logic [PERF_CNT_W-1:0]  perf_grant0,
    output logic [PERF_CNT_W-1:0]  perf_grant1
`endif
);

    logic                  ptr_q;
    logic                  valid_q;
    logic                  wd_q;
    logic [REG_AW-1:0]     wreg_q;
    logic [DATA_LEN-1:0]   wdata_q;
    logic [CSR_TYPE_W-1:0] csr_type_q;
    logic [CSR_AW-1:0]     csr_waddr_q;
    logic [DATA_LEN-1:0]   csr_wdata_q;

    logic can_load;
    logic xfer0, xfer1;

    assign can_load = !valid_q || m.ready;

    // Ready never looks at the source's own valid, only at the competitor.
    assign s0.ready = !reset && can_load && (!ptr_q || !s1.valid);
    assign s1.ready = !reset && can_load && ( ptr_q || !s0.valid);

    assign xfer0 = s0.valid && s0.ready;
    assign xfer1 = s1.valid && s1.ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q       <= 1'b0;
            valid_q     <= 1'b0;
            wd_q        <= 1'b0;
            wreg_q      <= '0;
            wdata_q     <= '0;
            csr_type_q  <= '0;
            csr_waddr_q <= '0;
            csr_wdata_q <= '0;
        end else if (xfer0 || xfer1) begin
            valid_q     <= 1'b1;
            ptr_q       <= xfer0;
            wd_q        <= xfer1 ? s1.wd        : s0.wd;
            wreg_q      <= xfer1 ? s1.wreg      : s0.wreg;
            wdata_q     <= xfer1 ? s1.wdata     : s0.wdata;
            csr_type_q  <= xfer1 ? s1.csr_type  : s0.csr_type;
            csr_waddr_q <= xfer1 ? s1.csr_waddr : s0.csr_waddr;
            csr_wdata_q <= xfer1 ? s1.csr_wdata : s0.csr_wdata;
        end else if (m.ready) begin
            valid_q <= 1'b0;
        end
    end

    // Stale data stays in the register; only the enables are qualified.
    assign m.valid     = valid_q;
    assign m.wd        = wd_q && valid_q && (wreg_q != '0);
    assign m.wreg      = wreg_q;
    assign m.wdata     = wdata_q;
    assign m.csr_type  = csr_type_q & {CSR_TYPE_W{valid_q}};
    assign m.csr_waddr = csr_waddr_q;
    assign m.csr_wdata = csr_wdata_q;

`ifdef WB_ARB_PERF_EN
    ysyx_23060025_wb_arb_perf u_perf (
        .clock         (clock),
        .reset         (reset),
        .s0_valid      (s0.valid),
        .s1_valid      (s1.valid),
        .m_valid       (valid_q),
        .m_allowin     (m.ready),
        .grant0        (xfer0),
        .grant1        (xfer1),
        .perf_conflict (perf_conflict),
        .perf_stall    (perf_stall),
        .perf_grant0   (perf_grant0),
        .perf_grant1   (perf_grant1)
    );
`endif

endmodule
